interrupt_claim_complete: RTL and testbench

Consumer side of the interrupt masking path. It takes the already-masked request vector, latches each source into a pending bit, and raises a single interrupt line to the core. It then runs a claim/complete handshake so that exactly one source is in service at a time. It sits between the interrupt mask stage and the core's external-interrupt input.

---
 rtl/interrupt_claim_complete.sv | 116 +++++++++++
 tb/tb_interrupt_claim_complete.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_claim_complete.sv
// Interrupt claim/complete controller: per-source pending gateways,
// lowest-ID arbitration and a one-source-in-service claim/complete handshake.

// Per-source gateway: latches a level request into a sticky pending bit.
module interrupt_gateway (
    input  logic CLK,
    input  logic nRST,
    input  logic req,
    input  logic gate_closed,
    input  logic clr,
    output logic pend
);
    // Set on a request while open; clear only when claimed or on reset.
    always_ff @(posedge CLK) begin
        if (!nRST)
            pend <= 1'b0;
        else if (pend)
            pend <= !clr;
        else
            pend <= req && !gate_closed;
    end
endmodule

module interrupt_claim_complete #(
    parameter int N_interrupts = 32,
    parameter int ID_W         = $clog2(N_interrupts)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [N_interrupts-1:0] interrupt_requests_masked,
    output logic                    interrupt_out,
    input  logic                    claim_req,
    output logic                    claim_ack,
    output logic [ID_W-1:0]         claim_id,
    output logic                    claim_empty,
    input  logic                    complete_req,
    input  logic [ID_W-1:0]         complete_id,
    output logic                    complete_err,
    output logic [N_interrupts-1:0] pending,
    output logic                    in_service
);
    localparam int unsigned NI = N_interrupts;

    typedef enum logic [1:0] {IDLE, NOTIFY, SERVICE} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] active_id;
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic            grant_take;
    logic            complete_ok;

    // Status decoded straight from the state register.
    assign interrupt_out = (state_q == NOTIFY);
    assign in_service    = (state_q == SERVICE);

    // One gateway per source; the active source's gate stays shut while in service.
    for (genvar i = 0; i < N_interrupts; i++) begin : g_gw
        interrupt_gateway u_gw (
            .CLK         (CLK),
            .nRST        (nRST),
            .req         (interrupt_requests_masked[i]),
            .gate_closed (in_service && (active_id == ID_W'(i))),
            .clr         (grant_take && (grant_id == ID_W'(i))),
            .pend        (pending[i])
        );
    end

    // Lowest set pending index wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = N_interrupts - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end

    // Claims only grant from NOTIFY; IDs outside the source range never match.
    assign grant_take  = claim_req && (state_q == NOTIFY) && grant_vld;
    assign complete_ok = complete_req && (state_q == SERVICE) &&
                         (complete_id == active_id) && (32'(complete_id) < NI);

    // Next-state logic for the claim/complete handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pending != '0) state_d = NOTIFY;
            NOTIFY:  if (grant_take)    state_d = SERVICE;
            SERVICE: if (complete_ok)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, active source and one-cycle handshake responses.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= IDLE;
            active_id    <= '0;
            claim_ack    <= 1'b0;
            claim_id     <= '0;
            claim_empty  <= 1'b0;
            complete_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            claim_ack    <= claim_req;
            claim_id     <= grant_take ? grant_id : '0;
            claim_empty  <= claim_req && !grant_take;
            complete_err <= complete_req && !complete_ok;
            if (grant_take)
                active_id <= grant_id;
        end
    end
endmodule

// File: tb/tb_interrupt_claim_complete.sv
// Self-checking bench: claim responses are scoreboarded, status is checked directly.
module tb_interrupt_claim_complete;
    localparam int N = 32;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [N-1:0] req = '0;
    logic         int_out, claim_req = 1'b0, claim_ack, claim_empty;
    logic [W-1:0] claim_id, complete_id = '0;
    logic         complete_req = 1'b0, complete_err, in_service;
    logic [N-1:0] pending;

    logic [7:0]   req8 = '0;
    logic         int8, claim8 = 1'b0, ack8, empty8, comp8 = 1'b0, err8, insvc8;
    logic [2:0]   cid8, compid8 = '0;
    logic [7:0]   pend8;

    int n_chk = 0;
    int n_fail = 0;
    logic [W:0] sb_q[$];   // {empty, id}

    always #5 clk = ~clk;

    interrupt_claim_complete #(.N_interrupts(N)) dut (
        .CLK(clk), .nRST(nrst), .interrupt_requests_masked(req),
        .interrupt_out(int_out), .claim_req(claim_req), .claim_ack(claim_ack),
        .claim_id(claim_id), .claim_empty(claim_empty), .complete_req(complete_req),
        .complete_id(complete_id), .complete_err(complete_err), .pending(pending),
        .in_service(in_service)
    );

    interrupt_claim_complete #(.N_interrupts(8), .ID_W(3)) dut8 (
        .CLK(clk), .nRST(nrst), .interrupt_requests_masked(req8),
        .interrupt_out(int8), .claim_req(claim8), .claim_ack(ack8),
        .claim_id(cid8), .claim_empty(empty8), .complete_req(comp8),
        .complete_id(compid8), .complete_err(err8), .pending(pend8),
        .in_service(insvc8)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic claim(input logic empty, input logic [W-1:0] id);
        claim_req = 1'b1;
        sb_q.push_back({empty, id});
    endtask

    task automatic complete(input logic [W-1:0] id);
        complete_req = 1'b1;
        complete_id  = id;
    endtask

    // Every claim_ack must match the oldest outstanding expected response.
    always @(negedge clk) begin
        if (claim_ack) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = sb_q.pop_front();
                chk("sb_claim", {26'd0, claim_empty, claim_id}, {26'd0, e});
            end
        end
    end

    initial begin
        // Reset
        step(2);
        chk("rst_pending", pending, 0);
        chk("rst_int", int_out, 0);
        chk("rst_ack", {claim_ack, claim_empty, complete_err, in_service}, 0);
        chk("rst_id", claim_id, 0);

        // Single source 5: latency and re-pend after completion
        nrst = 1'b1; req = 32'h20;
        step();
        chk("s1_pend", pending, 32'h20);
        chk("s1_int_t1", int_out, 0);
        step();
        chk("s1_int_t2", int_out, 1);
        claim(1'b0, 5'd5);
        step();
        claim_req = 1'b0;
        chk("s1_ack", claim_ack, 1);
        chk("s1_id", claim_id, 5);
        chk("s1_empty", claim_empty, 0);
        chk("s1_pend_clr", pending, 0);
        chk("s1_svc", in_service, 1);
        chk("s1_int_off", int_out, 0);
        step();
        chk("s1_ack_pulse", claim_ack, 0);
        chk("s1_gated", pending, 0);
        complete(5'd5);
        step();
        complete_req = 1'b0;
        chk("s1_idle", in_service, 0);
        chk("s1_err", complete_err, 0);
        chk("s1_not_yet", pending, 0);
        step();
        chk("s1_repend", pending, 32'h20);
        req = '0;
        step();
        claim(1'b0, 5'd5);
        step();
        claim_req = 1'b0;
        complete(5'd5);
        step();
        complete_req = 1'b0;

        // Sources 3 and 9: lowest wins, dropped request stays pending
        req = 32'h208;
        step();
        chk("s2_pend", pending, 32'h208);
        step();
        claim(1'b0, 5'd3);
        step();
        claim_req = 1'b0;
        chk("s2_id3", claim_id, 3);
        chk("s2_pend9", pending, 32'h200);
        step(2);
        chk("s2_no_repend", pending, 32'h200);
        req = '0;
        complete(5'd3);
        step();
        complete_req = 1'b0;
        chk("s2_idle_int", int_out, 0);
        chk("s2_idle_svc", in_service, 0);
        step();
        chk("s2_notify", int_out, 1);
        chk("s2_pend_kept", pending, 32'h200);
        claim(1'b0, 5'd9);
        step();
        claim_req = 1'b0;
        chk("s2_id9", claim_id, 9);
        chk("s2_pend0", pending, 0);
        complete(5'd9);
        step();
        complete_req = 1'b0;

        // Source 7: mismatched completion, then valid, then completion in IDLE
        req = 32'h80;
        step();
        req = '0;
        step();
        claim(1'b0, 5'd7);
        step();
        claim_req = 1'b0;
        complete(5'd6);
        step();
        chk("s3_err_mismatch", complete_err, 1);
        chk("s3_still_svc", in_service, 1);
        complete_req = 1'b0;
        step();
        chk("s3_err_pulse", complete_err, 0);
        complete(5'd7);
        step();
        chk("s3_ok", complete_err, 0);
        chk("s3_idle", in_service, 0);
        complete(5'd0);
        step();
        complete_req = 1'b0;
        chk("s3_err_idle", complete_err, 1);

        // Empty claim in IDLE; request arriving with a claim is not eligible
        claim(1'b1, 5'd0);
        step();
        claim_req = 1'b0;
        chk("s4_empty_ack", {claim_ack, claim_empty}, 2'b11);
        chk("s4_empty_id", claim_id, 0);
        chk("s4_no_svc", in_service, 0);
        req = 32'h10;
        step();
        req = '0;
        step();
        claim(1'b0, 5'd4);
        req = 32'h4;
        step();
        claim_req = 1'b0; req = '0;
        chk("s4_id4", claim_id, 4);
        chk("s4_pend2", pending, 32'h4);
        // claim + complete in SERVICE: completion wins, claim is empty
        claim(1'b1, 5'd0);
        complete(5'd4);
        step();
        claim_req = 1'b0; complete_req = 1'b0;
        chk("s4_svc_both_empty", claim_empty, 1);
        chk("s4_svc_both_err", complete_err, 0);
        chk("s4_svc_both_idle", in_service, 0);
        step();
        chk("s4_notify", int_out, 1);
        // claim + complete in NOTIFY: claim wins, completion errors
        claim(1'b0, 5'd2);
        complete(5'd2);
        step();
        claim_req = 1'b0; complete_req = 1'b0;
        chk("s4_ntf_both_id", {claim_empty, claim_id}, 6'd2);
        chk("s4_ntf_both_err", complete_err, 1);
        chk("s4_ntf_both_svc", in_service, 1);

        // Reset during SERVICE (source 2 active, so its gate is shut)
        req = 32'h0F;
        step();
        chk("s5_pend", pending, 32'h0B);
        nrst = 1'b0;
        step();
        chk("s5_rst_pend", pending, 0);
        chk("s5_rst_outs", {int_out, claim_ack, claim_empty, complete_err, in_service}, 0);
        nrst = 1'b1;
        step();
        chk("s5_repend", pending, 32'h0F);
        step();
        chk("s5_notify", int_out, 1);
        claim(1'b0, 5'd0);
        step();
        claim_req = 1'b0; req = '0;
        chk("s5_id0", claim_id, 0);
        chk("s5_pend_rest", pending, 32'h0E);

        // 8-source instance: top index claim and completion
        req8 = 8'h80;
        step();
        req8 = '0;
        chk("n8_pend", pend8, 8'h80);
        step();
        chk("n8_int", int8, 1);
        claim8 = 1'b1;
        step();
        claim8 = 1'b0;
        chk("n8_claim", {ack8, empty8, cid8}, {2'b10, 3'd7});
        chk("n8_svc", insvc8, 1);
        comp8 = 1'b1; compid8 = 3'd7;
        step();
        comp8 = 1'b0;
        chk("n8_idle", insvc8, 0);
        chk("n8_err", err8, 0);

        step(2);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
